// File: rtl/dff_ram_prog_if.sv
// Bus and programming-port bundle for dff_ram_prog.
// master: controller side, slave: RAM side.
interface dff_ram_prog_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] bus_in;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic              mi_n;
   logic              ri_n;
   logic              ro_n;
   logic [ADDR_W-1:0] mar_out;
   logic              prog_en;
   logic              prog_valid;
   logic [DATA_W-1:0] prog_data;
   logic              prog_ready;
   logic              prog_done;

   modport master (
      output bus_in, mi_n, ri_n, ro_n,
      output prog_en, prog_valid, prog_data,
      input  bus_out, bus_oe, mar_out,
      input  prog_ready, prog_done
   );

   modport slave (
      input  bus_in, mi_n, ri_n, ro_n,
      input  prog_en, prog_valid, prog_data,
      output bus_out, bus_oe, mar_out,
      output prog_ready, prog_done
   );
endinterface

// File: rtl/dff_ram_prog.sv
// Flip-flop RAM with MAR, strobed bus access and a
// streaming valid/ready port that fills the array from 0.
module dff_ram_prog #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input logic           clk,
   input logic           rst,
   dff_ram_prog_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PROG = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [ADDR_W-1:0] pa_q, pa_d;
   logic [DATA_W-1:0] bus_out_q, bus_out_d;
   logic              bus_oe_q, bus_oe_d;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   always_comb begin
      state_d   = state_q;
      mar_d     = mar_q;
      pa_d      = pa_q;
      bus_out_d = bus_out_q;
      bus_oe_d  = 1'b0;
      we        = 1'b0;
      waddr     = mar_q;
      wdata     = bus.bus_in;
      unique case (state_q)
         RUN: begin
            // read and write both use the pre-edge MAR
            if (!bus.ri_n) begin
               we    = 1'b1;
               waddr = mar_q;
               wdata = bus.bus_in;
            end
            if (!bus.mi_n) begin
               mar_d = bus.bus_in[ADDR_W-1:0];
            end
            if (!bus.ro_n && bus.ri_n) begin
               bus_out_d = mem_q[mar_q];
               bus_oe_d  = 1'b1;
            end
            if (bus.prog_en) begin
               state_d = PROG;
               pa_d    = '0;
            end
         end
         PROG: begin
            if (!bus.prog_en) begin
               state_d = RUN;
            end else if (bus.prog_valid) begin
               we    = 1'b1;
               waddr = pa_q;
               wdata = bus.prog_data;
               pa_d  = pa_q + ADDR_W'(1);
               if (&pa_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!bus.prog_en) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         mar_q     <= '0;
         pa_q      <= '0;
         bus_out_q <= '0;
         bus_oe_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         mar_q     <= mar_d;
         pa_q      <= pa_d;
         bus_out_q <= bus_out_d;
         bus_oe_q  <= bus_oe_d;
         if (we) begin
            mem_q[waddr] <= wdata;
         end
      end
   end

   assign bus.bus_out    = bus_out_q;
   assign bus.bus_oe     = bus_oe_q;
   assign bus.mar_out    = mar_q;
   assign bus.prog_ready = (state_q == PROG);
   assign bus.prog_done  = (state_q == DONE);
endmodule
